// File: rtl/stack_engine.sv
// Parametrised hardware stack with valid/ready op handshake, CALL/RET return-address support
// and a sticky ERROR state entered on overflow, underflow or a reserved opcode.
module stack_engine #(
  parameter int          WIDTH   = 32,
  parameter int          DEPTH   = 16,
  parameter logic [31:0] SP_BASE = 32'h0000_03FC
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [2:0]               op,
  input  logic                     op_valid,
  output logic                     op_ready,
  input  logic [WIDTH-1:0]         din,
  input  logic [WIDTH-1:0]         npc,
  input  logic                     clr_err,
  output logic [WIDTH-1:0]         dout,
  output logic                     dout_valid,
  output logic                     pc_load,
  output logic [WIDTH-1:0]         pc_tgt,
  output logic [31:0]              sp,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     err,
  output logic [1:0]               err_code
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_PUSH = 3'b001;
  localparam logic [2:0] OP_CALL = 3'b010;
  localparam logic [2:0] OP_POP  = 3'b011;
  localparam logic [2:0] OP_RET  = 3'b100;
  localparam logic [2:0] OP_REPL = 3'b101;

  typedef enum logic {IDLE, ERROR} state_t;

  state_t           state, state_next;
  logic [1:0]       err_code_next;
  logic             do_push, do_pop, do_ret, do_repl;
  logic [AW-1:0]    top;
  logic [WIDTH-1:0] push_data;
  logic [WIDTH-1:0] mem [DEPTH];

  assign op_ready  = (state == IDLE);
  assign err       = (state == ERROR);
  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  assign top       = count[AW-1:0] - 1'b1;
  assign push_data = (op == OP_CALL) ? npc : din;
  assign sp        = SP_BASE - {{(32-CW-2){1'b0}}, count, 2'b00};

  // Decode an accepted op; error cases leave the stack untouched and only move the FSM.
  always_comb begin
    state_next    = state;
    err_code_next = err_code;
    do_push       = 1'b0;
    do_pop        = 1'b0;
    do_ret        = 1'b0;
    do_repl       = 1'b0;
    case (state)
      IDLE: begin
        if (op_valid) begin
          case (op)
            OP_NOP: ;
            OP_PUSH, OP_CALL: begin
              if (full) begin
                state_next    = ERROR;
                err_code_next = 2'b01;
              end else begin
                do_push = 1'b1;
              end
            end
            OP_POP, OP_RET: begin
              if (empty) begin
                state_next    = ERROR;
                err_code_next = 2'b10;
              end else begin
                do_pop = 1'b1;
                do_ret = (op == OP_RET);
              end
            end
            OP_REPL: begin
              if (empty) begin
                state_next    = ERROR;
                err_code_next = 2'b10;
              end else begin
                do_repl = 1'b1;
              end
            end
            default: begin
              state_next    = ERROR;
              err_code_next = 2'b11;
            end
          endcase
        end
      end
      ERROR: begin
        if (clr_err) begin
          state_next    = IDLE;
          err_code_next = 2'b00;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      err_code <= 2'b00;
    end else begin
      state    <= state_next;
      err_code <= err_code_next;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count      <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      pc_load    <= 1'b0;
      pc_tgt     <= '0;
    end else begin
      dout_valid <= 1'b0;
      pc_load    <= 1'b0;
      if (do_push) begin
        count <= count + 1'b1;
      end
      if (do_pop) begin
        count      <= count - 1'b1;
        dout       <= mem[top];
        dout_valid <= 1'b1;
      end
      if (do_ret) begin
        pc_tgt  <= mem[top];
        pc_load <= 1'b1;
      end
      if (do_repl) begin
        dout       <= mem[top];
        dout_valid <= 1'b1;
      end
    end
  end

  // Storage is deliberately not reset; only count defines which entries are live.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[count[AW-1:0]] <= push_data;
    end else if (do_repl) begin
      mem[top] <= din;
    end
  end

endmodule
